// File: rtl/ysyx_25020047_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_mem_arbiter
//
// Shares the core's single data-memory port between the instruction fetch
// unit (IFU) and the load/store unit (LSU). One request is accepted at a
// time. It is latched, presented on the memory request channel, and the
// memory response is routed back to whichever requester issued it.
// LSU has priority. A starvation counter makes sure IFU wins a contended
// grant after STARVE_LIMIT consecutive LSU grants made while IFU waited.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ifu_req_valid/ready, ifu_addr IFU fetch request channel
//   ifu_resp_valid/ready/data     IFU fetch response channel
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask LSU load/store request channel
//   lsu_resp_valid/ready/data     LSU response channel
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask memory request channel (latched fields)
//   mem_resp_valid/ready/data     memory response channel
// ---------------------------------------------------------------------------
module ysyx_25020047_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    input  logic        ifu_resp_ready,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_data,
    input  logic        lsu_resp_ready,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mem_resp_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state_reg,  state_next;
    logic        owner_reg,  owner_next;    // 0 = IFU, 1 = LSU
    logic [3:0]  starve_reg, starve_next;
    logic [31:0] addr_reg,   addr_next;
    logic [31:0] wdata_reg,  wdata_next;
    logic        wen_reg,    wen_next;
    logic [3:0]  wmask_reg,  wmask_next;

    logic        starved;
    logic        grant_lsu;
    logic        grant_ifu;
    logic        owner_resp_ready;
    logic [3:0]  lsu_wmask_eff;

    // Loads never carry byte strobes downstream, whatever the LSU drives.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lsu_wmask_eff[gi] = lsu_wmask[gi] & lsu_wen;
        end
    endgenerate

    // Grant decision depends only on requester valids and local state, so
    // req_ready has no combinational dependency on the memory side.
    assign starved   = (starve_reg == LIMIT);
    assign grant_lsu = (state_reg == S_IDLE) && lsu_req_valid &&
                       (!ifu_req_valid || !starved);
    assign grant_ifu = (state_reg == S_IDLE) && ifu_req_valid &&
                       (!lsu_req_valid || starved);

    assign owner_resp_ready = owner_reg ? lsu_resp_ready : ifu_resp_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            owner_reg  <= 1'b0;
            starve_reg <= 4'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            wen_reg    <= 1'b0;
            wmask_reg  <= 4'd0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            wen_reg    <= wen_next;
            wmask_reg  <= wmask_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        starve_next = starve_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        wen_next    = wen_reg;
        wmask_next  = wmask_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (grant_lsu) begin
                    state_next = S_ISSUE;
                    owner_next = 1'b1;
                    addr_next  = lsu_addr;
                    wdata_next = lsu_wdata;
                    wen_next   = lsu_wen;
                    wmask_next = lsu_wmask_eff;
                    // Only count grants that actually kept IFU waiting.
                    if (ifu_req_valid && (starve_reg < LIMIT)) begin
                        starve_next = starve_reg + 4'd1;
                    end
                end else if (grant_ifu) begin
                    state_next  = S_ISSUE;
                    owner_next  = 1'b0;
                    addr_next   = ifu_addr;
                    wdata_next  = 32'd0;
                    wen_next    = 1'b0;
                    wmask_next  = 4'd0;
                    starve_next = 4'd0;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid && owner_resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Everything that could otherwise reflect a live input is gated by rst
    // so the block is fully silent while reset is held.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = 32'd0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = 32'd0;
        if (!rst) begin
            ifu_req_ready = grant_ifu;
            lsu_req_ready = grant_lsu;
            mem_req_valid = (state_reg == S_ISSUE);
            // Responses are forwarded only in WAIT; early ones are dropped.
            if (state_reg == S_WAIT) begin
                mem_resp_ready = owner_resp_ready;
                if (owner_reg) begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_resp_data  = mem_resp_data;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_resp_data  = mem_resp_data;
                end
            end
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wen   = wen_reg;
    assign mem_wmask = wmask_reg;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_25020047_mem_arbiter (STARVE_LIMIT = 4).
// A table of zero-wait transactions is replayed through one task, followed
// by hand-written sequences for starvation, back-pressure, reset during a
// transaction and stray responses.
// ---------------------------------------------------------------------------
module tb_ysyx_25020047_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = 32'd0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_ready = 1'b1;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = 32'd0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [3:0]  lsu_wmask = 4'd0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_ready = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'd0;
    logic        mem_resp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25020047_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_data(lsu_resp_data), .lsu_resp_ready(lsu_resp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic        exp_lsu;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [3:0]  exp_starve;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait transaction: grant at T, issue at T+1, response at T+2.
    task automatic run_vec(input vec_t v, input string tag);
        ifu_req_valid  = v.ifu_v;
        lsu_req_valid  = v.lsu_v;
        ifu_addr       = v.ifu_a;
        lsu_addr       = v.lsu_a;
        lsu_wen        = v.wen;
        lsu_wdata      = v.wdata;
        lsu_wmask      = v.wmask;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " ifu_req_ready@T"}, 32'(ifu_req_ready), 32'(!v.exp_lsu));
        chk({tag, " lsu_req_ready@T"}, 32'(lsu_req_ready), 32'(v.exp_lsu));
        chk({tag, " mem_req_valid@T"}, 32'(mem_req_valid), 32'd0);
        tick();
        if (v.exp_lsu) lsu_req_valid = 1'b0;
        else           ifu_req_valid = 1'b0;
        chk({tag, " starve"}, 32'(dut.starve_reg), 32'(v.exp_starve));
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk({tag, " mem_req_valid@T+1"}, 32'(mem_req_valid), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, v.exp_addr);
        chk({tag, " mem_wen"}, 32'(mem_wen), 32'(v.exp_wen));
        chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(v.exp_wmask));
        chk({tag, " req_ready@T+1"}, 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        @(negedge clk);
        if (v.exp_lsu) begin
            chk({tag, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd1);
            chk({tag, " lsu_resp_data"}, lsu_resp_data, v.rdata);
            chk({tag, " ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd0);
        end else begin
            chk({tag, " ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd1);
            chk({tag, " ifu_resp_data"}, ifu_resp_data, v.rdata);
            chk({tag, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
        end
        chk({tag, " mem_resp_ready"}, 32'(mem_resp_ready), 32'd1);
        chk({tag, " mem_req_valid@T+2"}, 32'(mem_req_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        $display("txn %s: winner=%s addr=%h wen=%0d wmask=%h resp=%h starve=%0d",
                 tag, v.exp_lsu ? "LSU" : "IFU", mem_addr, mem_wen, mem_wmask,
                 v.rdata, dut.starve_reg);
    endtask

    initial begin
        vec_t v;
        int   resp_count;
        logic [31:0] held_addr;

        // ifu_v lsu_v ifu_a lsu_a wen wdata wmask rdata | exp_lsu addr wen wdata wmask starve
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_0413,
                    1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,
                    1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'd1};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_0013,
                    1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 4'd0};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h8000_0100, 1'b0, 32'h1234_5678, 4'h3, 32'hCAFE_F00D,
                    1'b1, 32'h8000_0100, 1'b0, 32'h1234_5678, 4'h0, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h8000_0200, 1'b1, 32'h0000_BEEF, 4'h3, 32'h0,
                    1'b1, 32'h8000_0200, 1'b1, 32'h0000_BEEF, 4'h3, 4'd0};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_0008, 32'h8000_0300, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0093,
                    1'b0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 4'd0};

        // Reset: outputs silent even with a request pending.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        chk("rst ifu_req_ready", 32'(ifu_req_ready), 32'd0);
        chk("rst lsu_req_ready", 32'(lsu_req_ready), 32'd0);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst starve", 32'(dut.starve_reg), 32'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Starvation: IFU held valid, LSU issues back-to-back loads.
        for (int k = 0; k < 5; k++) begin
            v = '{1'b1, 1'b1, 32'h8000_0040, 32'h8000_1000 + 32'(k * 4), 1'b0, 32'h0, 4'h0,
                  32'h1000 + 32'(k), 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 4'd0};
            v.exp_lsu    = (k < 4);
            v.exp_addr   = (k < 4) ? v.lsu_a : v.ifu_a;
            v.exp_starve = (k < 4) ? 4'(k + 1) : 4'd0;
            run_vec(v, $sformatf("starve%0d", k));
        end
        lsu_req_valid = 1'b0;

        // Back-pressure on both request and response sides.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0300;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hA5A5_A5A5;
        lsu_wmask     = 4'hC;
        tick();
        lsu_req_valid = 1'b0;
        held_addr = mem_addr;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp mem_addr", mem_addr, 32'h8000_0300);
            chk("bp mem_wmask", 32'(mem_wmask), 32'hC);
            tick();
        end
        chk("bp addr stable", mem_addr, held_addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0;
        lsu_resp_ready = 1'b0;
        resp_count = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp mem_resp_ready", 32'(mem_resp_ready), 32'd0);
            if (lsu_resp_valid && lsu_resp_ready) resp_count++;
            tick();
        end
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        if (lsu_resp_valid && lsu_resp_ready) resp_count++;
        tick();
        // mem_resp_valid left high into IDLE: a stray response.
        @(negedge clk);
        if (lsu_resp_valid && lsu_resp_ready) resp_count++;
        chk("bp resp count", 32'(resp_count), 32'd1);
        chk("stray ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
        chk("stray lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
        chk("stray mem_resp_ready", 32'(mem_resp_ready), 32'd0);
        tick();
        chk("stray state idle", 32'(dut.state_reg), 32'd0);
        chk("stray mem_req_valid", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b0;
        $display("txn backpressure+stray: responses=%0d", resp_count);

        // Reset while waiting for the response.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0020;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h5555_AAAA;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
        chk("midrst ifu_resp_data", ifu_resp_data, 32'd0);
        chk("midrst mem_resp_ready", 32'(mem_resp_ready), 32'd0);
        chk("midrst mem_addr", mem_addr, 32'd0);
        chk("midrst req_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
        chk("midrst mem_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        chk("postrst state idle", 32'(dut.state_reg), 32'd0);
        $display("txn midreset: dropped in-flight fetch");
        v = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0010_0073,
              1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 4'd0};
        run_vec(v, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_mem_arbiter.md
# ysyx_25020047_mem_arbiter

Two-requester arbiter and sequencer that shares the core's single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time, latches it, drives it onto the memory request channel, and routes the memory response back to the requester that issued it. It sits between IFU/LSU and the memory/bus bridge. LSU has priority, and a starvation counter bounds how long IFU can be locked out.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive LSU grants, each made while IFU was waiting, after which IFU wins the next contended grant (range 1–15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ifu_req_valid  in  1  IFU fetch request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_resp_valid  out  1  fetch data valid.
- ifu_resp_data  out  32  fetch data.
- ifu_resp_ready  in  1  IFU takes the response.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data, already lane-aligned.
- lsu_wmask  in  4  byte-lane strobe for stores.
- lsu_resp_valid  out  1  load data or store acknowledge valid.
- lsu_resp_data  out  32  load data (undefined for stores).
- lsu_resp_ready  in  1  LSU takes the response.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr / mem_wdata  out  32 each  latched request fields.
- mem_wen  out  1  latched write enable.
- mem_wmask  out  4  latched write mask.
- mem_resp_valid  in  1  memory response valid.
- mem_resp_data  in  32  memory read data.
- mem_resp_ready  out  1  response accepted downstream.

## Operation
- **States.** The block has three states: IDLE, ISSUE and WAIT. It also holds an owner flag (0 = IFU, 1 = LSU) and a 4-bit starve counter.
- **IDLE, grant selection:**
  - Only LSU valid → grant LSU.
  - Only IFU valid → grant IFU.
  - Both valid → grant LSU, unless starve counter == STARVE_LIMIT, in which case grant IFU.
- **IDLE, grant actions:**
  - The winner's req_ready is 1 combinationally in the grant cycle.
  - Address, wen, wdata and wmask are latched, the owner flag is set, and the state moves to ISSUE.
  - A request that is not granted keeps req_ready = 0 and must hold its valid signal.
- **Latched fields for IFU requests:** wen = 0, wmask = 0, wdata = 0.
- **Latched fields for LSU loads:** wmask is forced to 0.
- **Starve counter:**
  - An LSU grant made while ifu_req_valid = 1 increments the counter, saturating at STARVE_LIMIT.
  - An IFU grant clears it to 0.
  - An LSU grant while IFU is idle leaves it unchanged.
- **ISSUE:** mem_req_valid = 1 with the latched fields. When mem_req_ready = 1, the state moves to WAIT.
- **WAIT:**
  - The owner's resp_valid = mem_resp_valid and its resp_data = mem_resp_data.
  - mem_resp_ready = the owner's resp_ready.
  - The non-owner's resp_valid = 0.
  - On the handshake (mem_resp_valid & owner resp_ready), the state moves to IDLE.
- **Single transaction in flight.** A new request is never accepted outside IDLE; both req_ready outputs are 0 in ISSUE and WAIT.
- **Early response.** A mem_resp_valid arriving in IDLE or ISSUE is ignored and never forwarded.

## Timing
- **Reset values:**
  - State IDLE, owner 0, starve counter 0, latched fields 0.
  - While rst = 1, every output is 0, including req_ready.
- **Reset mid-transaction.** The transaction is dropped without a response. mem_req_valid falls asynchronously with rst, and after release the block starts in IDLE.
- **Latency:**
  - Request accepted at cycle T.
  - mem_req_valid first at T+1.
  - With zero-wait memory (ready = 1 at T+1, resp_valid = 1 at T+2), the response handshake is at T+2.
  - The next grant is earliest at T+3.
  - Throughput is therefore 1 transaction per 3 cycles at best.
- **Back-pressure.** Any mem_req_ready or resp_ready back-pressure extends ISSUE/WAIT indefinitely, and the latched outputs stay stable throughout.
- **Combinational paths:**
  - mem_resp_valid/data → owner resp_valid/data.
  - owner resp_ready → mem_resp_ready.
  - No path exists from mem_* to req_ready.

## Test plan
- **Single read.** Reset, then IFU requests 0x8000_0000 and memory returns 0x0000_0413 → ifu_req_ready pulses at T, mem_addr = 0x8000_0000 with mem_wen = 0 at T+1, ifu_resp_data = 0x0000_0413 at T+2, lsu_resp_valid stays 0.
- **Contention.** IFU and LSU both valid in the same cycle, with LSU storing 0xDEADBEEF to 0x8000_0010 and wmask 0xF → LSU is granted first with mem_wen = 1 and mem_wmask = 0xF, IFU is granted on the following IDLE, and the counter goes 1 then 0.
- **Starvation.** IFU is held valid while LSU issues back-to-back loads, STARVE_LIMIT = 4 → LSU wins grants 1–4, IFU wins grant 5, and the counter returns to 0.
- **Back-pressure.** mem_req_ready is held 0 for 5 cycles, then lsu_resp_ready is held 0 for 3 cycles → mem_req_valid and fields stay stable for 5 cycles, mem_resp_ready = 0 for 3 cycles, then there is exactly one LSU response.
- **Reset mid-transaction.** rst is asserted asynchronously while in WAIT → all outputs are 0 immediately, no response is delivered, and a fresh IFU request after release completes normally.
- **Stray response.** mem_resp_valid = 1 in IDLE → both resp_valid outputs stay 0 and the state is unchanged.
